// File: rtl/pytxaclbufctrl.sv
// ACL TX payload buffer: two ping-pong SRAM banks between the
// baseband fill side (bsm) and the link-control send side (lnctrl).

module sram256x32_1p (
  input  logic        clk,
  input  logic [7:0]  a,
  input  logic [31:0] din,
  input  logic        we,
  input  logic        cs,
  output logic [31:0] dout
);

  logic [31:0] mem [256];

  // single-port array: write or 1-cycle registered read
  always_ff @(posedge clk) begin
    if (cs && we) mem[a] <= din;
    if (cs && !we) dout <= mem[a];
  end

endmodule

module pytxaclbufctrl (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic [7:0]  bsm_addr,
  input  logic [31:0] bsm_din,
  input  logic        bsm_we,
  input  logic        bsm_cs,
  input  logic        bsm_wrend_p,
  input  logic [9:0]  bsm_pylenByte,
  input  logic [7:0]  lnctrl_addr,
  input  logic        lnctrl_cs,
  input  logic        ms_tslot_p,
  input  logic        pk_encode,
  input  logic        tx_ack_p,
  input  logic        flush_p,
  output logic [31:0] lnctrl_dout,
  output logic [9:0]  txlenByte,
  output logic [7:0]  lnctrl_endaddr,
  output logic        txbuf_valid,
  output logic        regi_acltxbufempty,
  output logic        regi_acltxbuffull,
  output logic        regi_acltxovf
);

  logic       wptr;
  logic       rptr;
  logic [1:0] cnt;
  logic [9:0] len0;
  logic [9:0] len1;
  logic       sent;

  logic [7:0]  b_a    [2];
  logic [31:0] b_din  [2];
  logic        b_we   [2];
  logic        b_cs   [2];
  logic [31:0] b_dout [2];

  logic commit;
  logic ovf_hit;
  logic release_p;
  logic tx_start;

  assign commit    = bsm_wrend_p && (cnt != 2'd2);
  assign ovf_hit   = bsm_wrend_p && (cnt == 2'd2);
  assign release_p = tx_ack_p && sent && (cnt != 2'd0);
  assign tx_start  = ms_tslot_p && pk_encode && txbuf_valid;

  // bank ownership: send side first, then fill side, else idle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      b_a[i]   = 8'd0;
      b_din[i] = 32'd0;
      b_we[i]  = 1'b0;
      b_cs[i]  = 1'b0;
      if ((cnt != 2'd0) && (rptr == i[0])) begin
        b_a[i]  = lnctrl_addr;
        b_cs[i] = lnctrl_cs;
      end else if ((cnt != 2'd2) && (wptr == i[0])) begin
        b_a[i]   = bsm_addr;
        b_din[i] = bsm_din;
        b_we[i]  = bsm_we && bsm_cs;
        b_cs[i]  = bsm_cs;
      end
    end
  end

  sram256x32_1p u_b0 (
    .clk  (clk_6M),
    .a    (b_a[0]),
    .din  (b_din[0]),
    .we   (b_we[0]),
    .cs   (b_cs[0]),
    .dout (b_dout[0])
  );

  sram256x32_1p u_b1 (
    .clk  (clk_6M),
    .a    (b_a[1]),
    .din  (b_din[1]),
    .we   (b_we[1]),
    .cs   (b_cs[1]),
    .dout (b_dout[1])
  );

  // pointer/count/length bookkeeping; flush wins over everything
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      cnt           <= 2'd0;
      len0          <= 10'd0;
      len1          <= 10'd0;
      sent          <= 1'b0;
      regi_acltxovf <= 1'b0;
    end else if (flush_p) begin
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      cnt           <= 2'd0;
      len0          <= 10'd0;
      len1          <= 10'd0;
      sent          <= 1'b0;
      regi_acltxovf <= 1'b0;
    end else begin
      if (commit) begin
        if (wptr) len1 <= bsm_pylenByte;
        else      len0 <= bsm_pylenByte;
        wptr <= ~wptr;
      end
      if (release_p) rptr <= ~rptr;
      if (commit && !release_p) cnt <= cnt + 2'd1;
      if (!commit && release_p) cnt <= cnt - 2'd1;
      if (release_p)     sent <= 1'b0;
      else if (tx_start) sent <= 1'b1;
      if (ovf_hit) regi_acltxovf <= 1'b1;
    end
  end

  // send-side outputs decoded from registered state
  always_comb begin
    txbuf_valid        = (cnt != 2'd0);
    regi_acltxbufempty = (cnt == 2'd0);
    regi_acltxbuffull  = (cnt == 2'd2);
    txlenByte          = 10'd0;
    if (txbuf_valid) txlenByte = rptr ? len1 : len0;
    lnctrl_endaddr = 8'd0;
    if (txlenByte != 10'd0) begin
      if (txlenByte[1:0] == 2'd0)
        lnctrl_endaddr = txlenByte[9:2] - 8'd1;
      else
        lnctrl_endaddr = txlenByte[9:2];
    end
    lnctrl_dout = rptr ? b_dout[1] : b_dout[0];
  end

endmodule

// File: tb/tb_pytxaclbufctrl.sv
// Directed bench for the ping-pong ACL TX buffer.
// Inputs change 1 time unit after the rising edge; checks follow.

module tb_pytxaclbufctrl;

  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic [7:0]  bsm_addr = '0;
  logic [31:0] bsm_din = '0;
  logic        bsm_we = 1'b0;
  logic        bsm_cs = 1'b0;
  logic        bsm_wrend_p = 1'b0;
  logic [9:0]  bsm_pylenByte = '0;
  logic [7:0]  lnctrl_addr = '0;
  logic        lnctrl_cs = 1'b0;
  logic        ms_tslot_p = 1'b0;
  logic        pk_encode = 1'b0;
  logic        tx_ack_p = 1'b0;
  logic        flush_p = 1'b0;
  logic [31:0] lnctrl_dout;
  logic [9:0]  txlenByte;
  logic [7:0]  lnctrl_endaddr;
  logic        txbuf_valid;
  logic        regi_acltxbufempty;
  logic        regi_acltxbuffull;
  logic        regi_acltxovf;

  int total = 0;
  int bad = 0;

  always #5 clk_6M = ~clk_6M;

  pytxaclbufctrl dut (
    .clk_6M             (clk_6M),
    .rstz               (rstz),
    .bsm_addr           (bsm_addr),
    .bsm_din            (bsm_din),
    .bsm_we             (bsm_we),
    .bsm_cs             (bsm_cs),
    .bsm_wrend_p        (bsm_wrend_p),
    .bsm_pylenByte      (bsm_pylenByte),
    .lnctrl_addr        (lnctrl_addr),
    .lnctrl_cs          (lnctrl_cs),
    .ms_tslot_p         (ms_tslot_p),
    .pk_encode          (pk_encode),
    .tx_ack_p           (tx_ack_p),
    .flush_p            (flush_p),
    .lnctrl_dout        (lnctrl_dout),
    .txlenByte          (txlenByte),
    .lnctrl_endaddr     (lnctrl_endaddr),
    .txbuf_valid        (txbuf_valid),
    .regi_acltxbufempty (regi_acltxbufempty),
    .regi_acltxbuffull  (regi_acltxbuffull),
    .regi_acltxovf      (regi_acltxovf)
  );

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    bsm_addr = a; bsm_din = d;
    bsm_we = 1'b1; bsm_cs = 1'b1;
    step();
    bsm_we = 1'b0; bsm_cs = 1'b0;
  endtask

  task automatic commit(input logic [9:0] l);
    bsm_pylenByte = l; bsm_wrend_p = 1'b1;
    step();
    bsm_wrend_p = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    lnctrl_addr = a; lnctrl_cs = 1'b1;
    step();
    lnctrl_cs = 1'b0;
  endtask

  task automatic slot();
    ms_tslot_p = 1'b1; pk_encode = 1'b1;
    step();
    ms_tslot_p = 1'b0; pk_encode = 1'b0;
  endtask

  task automatic ack();
    tx_ack_p = 1'b1;
    step();
    tx_ack_p = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(txbuf_valid), 32'd0);
    chk({tag, ".len"}, 32'(txlenByte), 32'd0);
    chk({tag, ".end"}, 32'(lnctrl_endaddr), 32'd0);
    chk({tag, ".empty"}, 32'(regi_acltxbufempty), 32'd1);
    chk({tag, ".full"}, 32'(regi_acltxbuffull), 32'd0);
    chk({tag, ".ovf"}, 32'(regi_acltxovf), 32'd0);
  endtask

  initial begin
    #2;
    chk_reset("rst");
    step();
    rstz = 1'b1;
    step();
    chk_reset("post_rst");

    // ack while empty
    ack();
    chk("ack_empty.empty", 32'(regi_acltxbufempty), 32'd1);
    chk("ack_empty.valid", 32'(txbuf_valid), 32'd0);

    // fill b0, commit 17 bytes
    for (int i = 0; i < 5; i++)
      wr(8'(i), 32'hA0 + 32'(i));
    commit(10'd17);
    chk("c17.valid", 32'(txbuf_valid), 32'd1);
    chk("c17.len", 32'(txlenByte), 32'd17);
    chk("c17.end", 32'(lnctrl_endaddr), 32'd4);
    chk("c17.empty", 32'(regi_acltxbufempty), 32'd0);
    rd(8'd3);
    chk("rd3", lnctrl_dout, 32'hA3);

    // ack without a transmitted slot is ignored
    ack();
    chk("ack_nosent.len", 32'(txlenByte), 32'd17);
    chk("ack_nosent.full", 32'(regi_acltxbuffull), 32'd0);

    // fill b1, commit 27 bytes -> full
    wr(8'd0, 32'hB0);
    wr(8'd1, 32'hB1);
    commit(10'd27);
    chk("c27.full", 32'(regi_acltxbuffull), 32'd1);
    chk("c27.len", 32'(txlenByte), 32'd17);

    // overflow commit, blocked write
    commit(10'd5);
    chk("ovf.ovf", 32'(regi_acltxovf), 32'd1);
    chk("ovf.full", 32'(regi_acltxbuffull), 32'd1);
    wr(8'd3, 32'hDEAD);
    rd(8'd3);
    chk("blocked_wr", lnctrl_dout, 32'hA3);

    // NAK: two slots, no ack -> same bank
    slot();
    chk("nak1.len", 32'(txlenByte), 32'd17);
    rd(8'd0);
    chk("nak1.rd0", lnctrl_dout, 32'hA0);
    slot();
    chk("nak2.len", 32'(txlenByte), 32'd17);
    ack();
    chk("rel.len", 32'(txlenByte), 32'd27);
    chk("rel.end", 32'(lnctrl_endaddr), 32'd6);
    chk("rel.full", 32'(regi_acltxbuffull), 32'd0);
    chk("rel.ovf", 32'(regi_acltxovf), 32'd1);
    rd(8'd1);
    chk("rel.rd1", lnctrl_dout, 32'hB1);

    // commit and release in the same cycle
    slot();
    wr(8'd2, 32'hC2);
    bsm_pylenByte = 10'd12;
    bsm_wrend_p = 1'b1;
    tx_ack_p = 1'b1;
    step();
    bsm_wrend_p = 1'b0;
    tx_ack_p = 1'b0;
    chk("both.valid", 32'(txbuf_valid), 32'd1);
    chk("both.full", 32'(regi_acltxbuffull), 32'd0);
    chk("both.len", 32'(txlenByte), 32'd12);
    chk("both.end", 32'(lnctrl_endaddr), 32'd2);
    rd(8'd2);
    chk("both.rd2", lnctrl_dout, 32'hC2);

    // fill up, overflow, then flush
    commit(10'd4);
    chk("c4.full", 32'(regi_acltxbuffull), 32'd1);
    commit(10'd9);
    chk("c9.ovf", 32'(regi_acltxovf), 32'd1);
    flush_p = 1'b1;
    step();
    flush_p = 1'b0;
    chk_reset("flush");

    // fresh 8 / 27, third commit rejected
    commit(10'd8);
    chk("f8.end", 32'(lnctrl_endaddr), 32'd1);
    commit(10'd27);
    chk("f27.full", 32'(regi_acltxbuffull), 32'd1);
    commit(10'd9);
    chk("f9.ovf", 32'(regi_acltxovf), 32'd1);
    chk("f9.len", 32'(txlenByte), 32'd8);
    slot();
    ack();
    chk("f9.len1", 32'(txlenByte), 32'd27);
    chk("f9.end1", 32'(lnctrl_endaddr), 32'd6);

    // async reset mid-fill
    bsm_addr = 8'd5; bsm_din = 32'h55;
    bsm_we = 1'b1; bsm_cs = 1'b1;
    #3;
    rstz = 1'b0;
    #1;
    chk_reset("arst");
    bsm_we = 1'b0; bsm_cs = 1'b0;
    step();
    rstz = 1'b1;
    step();
    chk_reset("arst_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
